// File: rtl/data_sync.sv
// Destination-side bus synchronizer: the enable level passes through a flop chain and its
// rising edge captures a held-stable bus, which is offered downstream via valid/ready.
`timescale 1ns/1ps
module data_sync #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  input  logic                 sync_ready,
  output logic                 enable_pulse,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  logic [NUM_STAGES-1:0] sync_ff_q;
  logic                  en_q;
  logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
  logic                  sync_valid_q, sync_valid_d;
  logic                  enable_pulse_q;
  logic                  overrun_q, overrun_d;
  logic                  rise;
  logic                  accept;

  // Only the enable level is metastability-hardened; the bus is already stable when sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_ff_q <= '0;
      en_q      <= 1'b0;
    end else begin
      sync_ff_q <= {sync_ff_q[NUM_STAGES-2:0], bus_enable};
      en_q      <= sync_ff_q[NUM_STAGES-1];
    end
  end

  assign rise   = sync_ff_q[NUM_STAGES-1] & ~en_q;
  assign accept = sync_valid_q & sync_ready;

  always_comb begin
    sync_bus_d   = sync_bus_q;
    sync_valid_d = sync_valid_q;
    overrun_d    = overrun_q;
    if (rise) begin
      sync_bus_d   = unsync_bus;
      sync_valid_d = 1'b1;
    end else if (accept) begin
      sync_valid_d = 1'b0;
    end
    // A capture over an unconsumed word sets the flag, and that beats a same-cycle clear.
    if (rise && sync_valid_q && !sync_ready) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_bus_q     <= '0;
      sync_valid_q   <= 1'b0;
      enable_pulse_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sync_bus_q     <= sync_bus_d;
      sync_valid_q   <= sync_valid_d;
      enable_pulse_q <= rise;
      overrun_q      <= overrun_d;
    end
  end

  assign sync_bus     = sync_bus_q;
  assign sync_valid   = sync_valid_q;
  assign enable_pulse = enable_pulse_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/data_sync.md
# data_sync

Parametrised bus synchronizer on the destination side of a clock-domain crossing. It replaces the single-bit reset synchronizer pattern with a multi-bit data path. It synchronizes a source-domain enable level through a configurable flip-flop chain, detects the enable rising edge, and captures a held-stable data bus. The captured word is then offered to the destination logic through a valid/ready handshake, with a sticky overrun flag. It sits in the sync layer between the UART/system clock domains, for example on configuration words and RX data crossing into the processing-unit clock.

## Interface
- BUS_WIDTH, 8: width of the crossing data bus; legal range ≥1.
- NUM_STAGES, 2: flip-flops in the enable synchronizer chain; legal range ≥2.
- clk  input  1  destination-domain clock; all flops on rising edge.
- rst  input  1  asynchronous, active-low reset; assertion clears all flops immediately; deassertion is synchronous to clk (driven by rst_sync).
- unsync_bus  input  BUS_WIDTH  source-domain data; stable while bus_enable is high.
- bus_enable  input  1  source-domain qualifier level; rising edge marks new data.
- sync_bus  output  BUS_WIDTH  captured data, registered.
- sync_valid  output  1  captured word pending for the consumer.
- sync_ready  input  1  consumer accepts sync_bus in any cycle where sync_valid & sync_ready.
- enable_pulse  output  1  one-cycle strobe, registered, in the cycle after each capture.
- overrun  output  1  sticky; a new word was captured while the previous one was still unconsumed.
- overrun_clr  input  1  synchronous clear of overrun.

## Operation
- Enable chain: sync_ff[0] samples bus_enable; sync_ff[i] samples sync_ff[i-1]; en_q is a register of sync_ff[NUM_STAGES-1].
- Edge detect: rise = sync_ff[NUM_STAGES-1] & ~en_q. A falling edge of bus_enable is ignored.
- On rise:
  - sync_bus <= unsync_bus; the bus must already be stable, so it is not multi-flop synchronized.
  - enable_pulse <= 1, for exactly one cycle.
  - sync_valid <= 1.
- With no rise, enable_pulse <= 0.
- Handshake:
  - sync_valid & sync_ready & ~rise: sync_valid <= 0 and sync_bus is held.
  - With neither rise nor acceptance, sync_valid and sync_bus hold.
- Simultaneous rise and acceptance: the old word is consumed, the new word is captured, sync_valid stays 1, and overrun is unaffected.
- Overrun:
  - rise while sync_valid & ~sync_ready: the newest word overwrites sync_bus, sync_valid stays 1, and overrun <= 1.
  - overrun_clr alone: overrun <= 0.
  - Set and clear in the same cycle: set wins.
- Source rules:
  - bus_enable high and low phases last ≥ NUM_STAGES+1 clk cycles each.
  - unsync_bus is stable from before the bus_enable rise until after it falls.
- Violating a source rule may drop an event. The block must never emit more than one enable_pulse per high phase.
- Reset: sync_ff, en_q, sync_bus, sync_valid, enable_pulse and overrun are all 0. No output is X after reset.

## Timing
- Let E0 be the first rising clk edge that samples bus_enable = 1.
- sync_ff[NUM_STAGES-1] = 1 after edge E(NUM_STAGES-1), and rise is true in the following cycle.
- sync_bus, sync_valid and enable_pulse update at edge E(NUM_STAGES). Latency is NUM_STAGES+1 edges; for NUM_STAGES=2 the outputs change at the third edge.
- enable_pulse is high for exactly one cycle per event. sync_valid remains high until the accept edge.
- Acceptance takes effect at the edge where sync_valid & sync_ready is sampled; sync_valid is low in the next cycle.
- Throughput: with sync_ready held at 1, one word per bus_enable period. The minimum period is 2·(NUM_STAGES+1) cycles.
- Reset mid-transfer: all state clears asynchronously. A bus_enable still high after reset release is seen as a new rising edge and captured once, after NUM_STAGES+1 edges.

## Test plan
- Reset: drive rst=0 with bus_enable=1 and unsync_bus=8'hFF. All outputs must be 0. Release rst with bus_enable held high: exactly one capture of 8'hFF, with enable_pulse high for 1 cycle exactly 3 edges after release (NUM_STAGES=2).
- Basic transfer: NUM_STAGES=2, unsync_bus=8'hA5, bus_enable high for 4 cycles, sync_ready=1. Required: sync_bus=8'hA5, sync_valid high 1 cycle, enable_pulse high 1 cycle at the third edge, overrun=0.
- Backpressure/overrun: sync_ready=0; send 8'h11 then 8'h22. Required: sync_bus=8'h22, sync_valid=1, overrun=1. Assert sync_ready for 1 cycle: sync_valid=0 and overrun still 1. Pulse overrun_clr: overrun=0.
- Simultaneous events:
  - Hold sync_ready low until the cycle the second capture lands, so that accept and capture coincide. Required: sync_valid stays 1, sync_bus updates, overrun=0.
  - overrun_clr coinciding with an overrun set: overrun=1.
- Parameter sweep: BUS_WIDTH=1/8/32 and NUM_STAGES=2/3/4, with 100 random words, random gaps ≥ NUM_STAGES+1 and sync_ready=1. Required:
  - The scoreboard matches every word in order.
  - Latency is always NUM_STAGES+1 edges.
  - The enable_pulse count equals the bus_enable rising-edge count.
- Glitch rejection: a 1-cycle bus_enable pulse is captured at most once. A falling edge never produces enable_pulse.
